// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for a 5-stage pipeline: per-stage write enables and flushes,
// saturating stall/flush counters and a sticky memory-wait timeout.
module pipeline_stall_ctrl #(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_alu,
   input  logic             redirect,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idex_we,
   output logic             idex_flush,
   output logic             exmem_we,
   output logic             memwb_flush,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count,
   output logic             mem_timeout
);

   typedef enum logic [1:0] {RUN = 2'd0, LUSTALL = 2'd1, MEMWAIT = 2'd2} state_t;

   localparam logic [7:0] TO_LIM = 8'(MEM_TIMEOUT - 1);

   state_t     cur, nxt;
   logic [7:0] wait_cnt;
   logic       waiting, take_redir;

   assign state      = cur;
   assign waiting    = dmem_req && !dmem_ready;
   assign take_redir = !waiting && redirect;

   always_comb begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      ifid_flush  = 1'b0;
      idex_we     = 1'b1;
      idex_flush  = 1'b0;
      exmem_we    = 1'b1;
      memwb_flush = 1'b0;
      nxt         = RUN;
      if (rst) begin
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         memwb_flush = 1'b1;
      end else if (waiting) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_we     = 1'b0;
         exmem_we    = 1'b0;
         memwb_flush = 1'b1;
         nxt         = MEMWAIT;
      end else if (redirect) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (stall_alu && cur != LUSTALL) begin
         // Only one bubble per load: the cycle after a stall never stalls again.
         pc_we      = 1'b0;
         ifid_we    = 1'b0;
         idex_we    = 1'b0;
         idex_flush = 1'b1;
         nxt        = LUSTALL;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur          <= RUN;
         stall_cycles <= '0;
         flush_count  <= '0;
         mem_timeout  <= 1'b0;
         wait_cnt     <= '0;
      end else begin
         cur <= nxt;
         if (!pc_we && stall_cycles != '1)
            stall_cycles <= stall_cycles + CNT_W'(1);
         if (take_redir && flush_count != '1)
            flush_count <= flush_count + CNT_W'(1);
         if (waiting) begin
            if (wait_cnt >= TO_LIM)
               mem_timeout <= 1'b1;
            if (wait_cnt != 8'hFF)
               wait_cnt <= wait_cnt + 8'd1;
         end else begin
            wait_cnt <= '0;
         end
      end
   end

endmodule
